// File: rtl/mux_pipe_sel.sv
// N-way WIDTH-bit selector feeding a two-entry skid buffer.
// One-cycle latency, full throughput, in_ready driven from registered state.
module mux_pipe_sel #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] d_in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  sel_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] word;
  logic             bad;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic             main_err_q, main_err_d;
  logic             main_vld_q, main_vld_d;

  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_err_q, skid_err_d;
  logic             skid_vld_q, skid_vld_d;

  logic accept;

  // Out-of-range indices select zero and raise the error flag.
  always_comb begin
    word = '0;
    bad  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(sel) == k) begin
        word = d_in[k*WIDTH +: WIDTH];
        bad  = 1'b0;
      end
    end
  end

  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    main_err_d  = main_err_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;
    skid_vld_d  = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q && out_ready) begin
      main_data_d = skid_data_q;
      main_sel_d  = skid_sel_q;
      main_err_d  = skid_err_q;
      main_vld_d  = 1'b1;
      skid_vld_d  = 1'b0;
    end else if (accept && (!main_vld_q || out_ready)) begin
      main_data_d = word;
      main_sel_d  = sel;
      main_err_d  = bad;
      main_vld_d  = 1'b1;
    end else if (accept) begin
      skid_data_d = word;
      skid_sel_d  = sel;
      skid_err_d  = bad;
      skid_vld_d  = 1'b1;
    end else if (main_vld_q && out_ready) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      main_sel_q  <= '0;
      main_err_q  <= 1'b0;
      main_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      main_err_q  <= main_err_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_err_q  <= skid_err_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign sel_err   = main_err_q;
  assign out_valid = main_vld_q;

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Scoreboard bench for mux_pipe_sel: N_IN=4 and N_IN=3 instances
// driven with identical stimulus and checked against queue models.
module tb_mux_pipe_sel;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] d_in;
  logic [1:0]   sel;
  logic         in_valid, flush, out_ready;

  logic        r4, v4, e4;
  logic [31:0] d4;
  logic [1:0]  s4;
  logic        r3, v3, e3;
  logic [31:0] d3;
  logic [1:0]  s3;

  always #5 clk = ~clk;

  mux_pipe_sel #(.WIDTH(32), .N_IN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .sel(sel),
    .in_valid(in_valid), .in_ready(r4), .flush(flush),
    .out_data(d4), .out_sel(s4), .sel_err(e4),
    .out_valid(v4), .out_ready(out_ready)
  );

  mux_pipe_sel #(.WIDTH(32), .N_IN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in[95:0]), .sel(sel),
    .in_valid(in_valid), .in_ready(r3), .flush(flush),
    .out_data(d3), .out_sel(s3), .sel_err(e3),
    .out_valid(v3), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [127:0] d,
                                 input logic [1:0] s, input int n);
    exp_t x;
    x.s = s;
    if (int'(s) < n) begin
      x.d = 32'(d >> (32 * int'(s)));
      x.e = 1'b0;
    end else begin
      x.d = '0;
      x.e = 1'b1;
    end
    return x;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] lane(input logic [127:0] d, input int k);
    return 32'(d >> (32 * k));
  endfunction

  // Drive one cycle; expected words are queued on accept.
  task automatic cyc(input logic v, input logic [1:0] s,
                     input logic [127:0] d, input logic ordy,
                     input logic fl);
    in_valid  = v;
    sel       = s;
    d_in      = d;
    out_ready = ordy;
    flush     = fl;
    if (v && r4 && !fl) q4.push_back(model(d, s, 4));
    if (v && r3 && !fl) q3.push_back(model(d, s, 3));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (rst_n) begin
      chk("inflight4", 32'(q4.size() <= 2), 32'd1);
      chk("inflight3", 32'(q3.size() <= 2), 32'd1);
      if (v4 && out_ready) begin
        if (q4.size() == 0) begin
          chk("u4_unexpected", 32'(v4), 32'd0);
        end else begin
          x = q4.pop_front();
          chk("u4_data", d4, x.d);
          chk("u4_sel", 32'(s4), 32'(x.s));
          chk("u4_err", 32'(e4), 32'(x.e));
        end
      end
      if (v3 && out_ready) begin
        if (q3.size() == 0) begin
          chk("u3_unexpected", 32'(v3), 32'd0);
        end else begin
          x = q3.pop_front();
          chk("u3_data", d3, x.d);
          chk("u3_sel", 32'(s3), 32'(x.s));
          chk("u3_err", 32'(e3), 32'(x.e));
        end
      end
      if (flush) begin
        q4.delete();
        q3.delete();
      end
    end
  end

  initial begin
    logic [127:0] dd, da, db, dc;
    in_valid  = 1'b0;
    sel       = '0;
    d_in      = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(v4), 32'd0);
    chk("rst_ready", 32'(r4), 32'd1);
    chk("rst_data", d4, 32'd0);
    chk("rst_sel", 32'(s4), 32'd0);
    chk("rst_err", 32'(e4), 32'd0);
    rst_n = 1'b1;

    // streaming
    dd = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'(i), dd, 1'b1, 1'b0);
      chk("stream_valid", 32'(v4), 32'd1);
      chk("stream_data", d4, lane(dd, i));
      chk("stream_sel", 32'(s4), 32'(i));
    end
    chk("oor_data", d3, 32'd0);
    chk("oor_err", 32'(e3), 32'd1);
    cyc(1'b1, 2'd2, dd, 1'b1, 1'b0);
    chk("oor_next_data", d3, 32'hCCCC0002);
    chk("oor_next_err", 32'(e3), 32'd0);
    cyc(1'b0, 2'd0, dd, 1'b1, 1'b0);
    chk("stream_idle", 32'(v4), 32'd0);

    // stall and skid
    da = rnd128();
    db = rnd128();
    dc = rnd128();
    cyc(1'b1, 2'd0, da, 1'b0, 1'b0);
    chk("stall_a_valid", 32'(v4), 32'd1);
    chk("stall_a_data", d4, lane(da, 0));
    chk("stall_a_ready", 32'(r4), 32'd1);
    cyc(1'b1, 2'd1, db, 1'b0, 1'b0);
    chk("stall_b_ready", 32'(r4), 32'd0);
    chk("stall_b_hold", d4, lane(da, 0));
    cyc(1'b1, 2'd2, dc, 1'b0, 1'b0);
    chk("stall_c_ready", 32'(r4), 32'd0);
    chk("stall_c_hold", d4, lane(da, 0));
    cyc(1'b1, 2'd2, dc, 1'b1, 1'b0);
    chk("drain_b_data", d4, lane(db, 1));
    chk("drain_b_valid", 32'(v4), 32'd1);
    chk("drain_b_ready", 32'(r4), 32'd1);
    cyc(1'b1, 2'd2, dc, 1'b1, 1'b0);
    chk("drain_c_data", d4, lane(dc, 2));
    chk("drain_c_valid", 32'(v4), 32'd1);
    cyc(1'b0, 2'd0, dc, 1'b1, 1'b0);
    chk("drain_idle", 32'(v4), 32'd0);

    // flush with concurrent input
    cyc(1'b1, 2'd0, da, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, db, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, dc, 1'b0, 1'b1);
    chk("flush_valid", 32'(v4), 32'd0);
    chk("flush_ready", 32'(r4), 32'd1);
    chk("flush_valid3", 32'(v3), 32'd0);
    cyc(1'b0, 2'd0, dc, 1'b1, 1'b0);
    chk("flush_after", 32'(v4), 32'd0);

    // asynchronous reset mid-stall
    cyc(1'b1, 2'd0, da, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, db, 1'b0, 1'b0);
    chk("full_ready", 32'(r4), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v4), 32'd0);
    chk("arst_ready", 32'(r4), 32'd1);
    chk("arst_data", d4, 32'd0);
    chk("arst_valid3", 32'(v3), 32'd0);
    q4.delete();
    q3.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 2'd2, dc, 1'b1, 1'b0);
    chk("post_rst_valid", 32'(v4), 32'd1);
    chk("post_rst_data", d4, lane(dc, 2));
    cyc(1'b0, 2'd0, dc, 1'b1, 1'b0);

    // random traffic
    repeat (10000) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd128(),
          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end
    repeat (6) cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("drain_q4", 32'(q4.size()), 32'd0);
    chk("drain_q3", 32'(q3.size()), 32'd0);
    chk("final_valid", 32'(v4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_pipe_sel.md
Name: mux_pipe_sel

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered, flow-controlled output stage.
- Next generation of the fixed 2/4-input datapath selectors, for the pipelined core: forwarding-operand and writeback-source selection across a stage boundary.
- Combinational N:1 select feeds a 2-entry skid buffer: one-cycle latency, full throughput, stall and flush support.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of inputs (2..16).
- SEL_W, $clog2(N_IN), select width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_in  in  N_IN*WIDTH  packed inputs; input k = d_in[k*WIDTH +: WIDTH].
- sel  in  SEL_W  input index, sampled with in_valid.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  synchronous discard of all held words.
- out_data  out  WIDTH  selected word (registered).
- out_sel  out  SEL_W  index that produced out_data (registered).
- sel_err  out  1  out-of-range select for the word on out_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Accept condition: in_valid && in_ready && !flush.
- Transfer condition: out_valid && out_ready.
- Select:
  - sel < N_IN: word = slice sel of d_in, err = 0.
  - sel >= N_IN (only possible when N_IN is not a power of 2): word = 0, err = 1.
  - Word, sel and err are captured together.
- Storage: main register {out_data, out_sel, sel_err, out_valid} plus skid register {data, sel, err, skid_valid}.
- in_ready = !skid_valid. Depends on registered state only; no combinational path from out_ready.
- Next-state rules, evaluated in priority order at each rising edge:
  1. flush: out_valid <= 0, skid_valid <= 0; data fields hold their values; any concurrent accept is dropped.
  2. skid_valid && out_ready: main <= skid contents; skid_valid <= 0. No accept is possible this cycle (in_ready = 0).
  3. Accept && (!out_valid || out_ready): main <= new word; out_valid <= 1.
  4. Accept && out_valid && !out_ready: skid <= new word; skid_valid <= 1; main holds.
  5. Transfer with no accept: out_valid <= 0.
  6. Otherwise: hold.
- Latency: a word accepted at edge N is presented on the outputs after edge N; a word fed every cycle with out_ready = 1 is sustained at 1 word/cycle.
- Ordering: strict FIFO order. No word is duplicated or lost except by flush.
- Stall: with out_ready = 0, at most two words are held. in_ready falls the cycle after the second accept.
- Recovery: out_ready rising with skid full drains the skid into main; in_ready returns high the next cycle.
- While out_valid = 1 and out_ready = 0, out_data/out_sel/sel_err are stable.
- Reset (asynchronous, any time, including mid-stall): out_valid = 0, skid_valid = 0, out_data = 0, out_sel = 0, sel_err = 0, skid data = 0; in_ready = 1 while reset is held and after it is released.
- flush and reset leave no residual valid state; the first accept after either behaves as accept into an empty stage.

Test Plan:
- Reset: assert rst_n = 0 mid-stall with both entries full -> out_valid = 0 and in_ready = 1 immediately, out_data = 0; after release, first word passes normally.
- Streaming: WIDTH = 32, N_IN = 4, d_in = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, sel cycling 0,1,2,3, out_ready = 1 -> out_data 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 on consecutive cycles, one cycle after each accept; out_sel matches.
- Stall/skid: out_ready = 0, send words A, B, C -> A on out_data, in_ready = 0 after B, C held off upstream; raise out_ready -> A, B, C delivered in order with no gaps.
- Out-of-range: N_IN = 3, sel = 3 -> out_data = 0, sel_err = 1; next word with sel = 2 -> sel_err = 0, correct data.
- Flush: two words held, flush = 1 concurrent with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, flushed and concurrent words never appear.
- Random: random in_valid/out_ready/sel against a scoreboard for 10k cycles -> output sequence equals the accepted-word sequence, never more than 2 words in flight.
